// File: rtl/parser_rule_lookup.sv
// Rule table plus 3-stage header lookup: type-field extract, masked priority match, key extract.
// The table is written by per-rule strobes; the pipeline reads it live.
module parser_rule_lookup #(
  parameter int HDR_WIDTH         = 512,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_OFFSET_WIDTH = 6,
  parameter int TYPE_WIDTH        = 16,
  parameter int KEY_FILED_NUM     = 8,
  parameter int KEY_OFFSET_WIDTH  = 6,
  parameter int RULE_NUM          = 8,
  parameter int RID_W             = $clog2(RULE_NUM)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     i_type_offset,
  input  logic [RULE_NUM-1:0]                       i_typeRule_wren,
  input  logic                                      i_typeRule_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_typeRule_typeData,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_typeRule_typeMask,
  input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] i_typeRule_keyOffset,
  input  logic                                      i_hdr_valid,
  input  logic [HDR_WIDTH-1:0]                      i_hdr_data,
  output logic                                      o_hdr_ready,
  output logic                                      o_key_valid,
  input  logic                                      i_key_ready,
  output logic [KEY_FILED_NUM*16-1:0]               o_key_data,
  output logic                                      o_rule_hit,
  output logic [RID_W-1:0]                          o_rule_id
);

  localparam int TDW = TYPE_NUM * TYPE_WIDTH;
  localparam int KOW = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
  localparam int KDW = KEY_FILED_NUM * 16;

  // Shifting the window left by the byte offset leaves the two target bytes on top;
  // bytes past the end of the header shift in as zero.
  function automatic logic [15:0] get_field(input logic [HDR_WIDTH-1:0] hdr,
                                            input logic [15:0]          byte_off);
    logic [HDR_WIDTH-1:0] shifted;
    shifted = hdr << {byte_off, 3'b000};
    return shifted[HDR_WIDTH-1 -: 16];
  endfunction

  logic [RULE_NUM-1:0] tbl_valid;
  logic [TDW-1:0]      tbl_data [RULE_NUM];
  logic [TDW-1:0]      tbl_mask [RULE_NUM];
  logic [KOW-1:0]      tbl_koff [RULE_NUM];

  logic                 s1_valid;
  logic [HDR_WIDTH-1:0] s1_hdr;
  logic [TDW-1:0]       s1_fields;
  logic                 s2_valid;
  logic [HDR_WIDTH-1:0] s2_hdr;
  logic                 s2_hit;
  logic [RID_W-1:0]     s2_id;
  logic [KOW-1:0]       s2_koff;

  logic                 s1_ready;
  logic                 s2_ready;
  logic                 s3_ready;
  logic [TDW-1:0]       type_fields;
  logic [RULE_NUM-1:0]  rule_hit;
  logic                 match_hit;
  logic [RID_W-1:0]     match_id;
  logic [KOW-1:0]       match_koff;
  logic [KDW-1:0]       key_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tbl_valid <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (i_typeRule_wren[r]) tbl_valid[r] <= i_typeRule_valid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < RULE_NUM; r++) begin
      if (i_typeRule_wren[r]) begin
        tbl_data[r] <= i_typeRule_typeData;
        tbl_mask[r] <= i_typeRule_typeMask;
        tbl_koff[r] <= i_typeRule_keyOffset;
      end
    end
  end

  assign s3_ready    = ~o_key_valid | i_key_ready;
  assign s2_ready    = ~s2_valid | s3_ready;
  assign s1_ready    = ~s1_valid | s2_ready;
  assign o_hdr_ready = s1_ready;

  always_comb begin
    type_fields = '0;
    for (int t = 0; t < TYPE_NUM; t++) begin
      type_fields[t*TYPE_WIDTH +: TYPE_WIDTH] =
        get_field(i_hdr_data, 16'(i_type_offset[t*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH]));
    end
  end

  // Match runs while the header sits in s1 and is captured into s2, so a same-cycle
  // table write is seen only by later headers.
  always_comb begin
    rule_hit = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      rule_hit[r] = tbl_valid[r] & (((s1_fields ^ tbl_data[r]) & tbl_mask[r]) == '0);
    end
  end

  always_comb begin
    match_hit  = 1'b0;
    match_id   = '0;
    match_koff = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (rule_hit[r]) begin
        match_hit  = 1'b1;
        match_id   = RID_W'(r);
        match_koff = tbl_koff[r];
      end
    end
  end

  always_comb begin
    key_next = '0;
    if (s2_hit) begin
      for (int k = 0; k < KEY_FILED_NUM; k++) begin
        key_next[k*16 +: 16] =
          get_field(s2_hdr, 16'(s2_koff[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH]));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      o_key_valid <= 1'b0;
      o_key_data  <= '0;
      o_rule_hit  <= 1'b0;
      o_rule_id   <= '0;
    end else begin
      if (s1_ready) s1_valid <= i_hdr_valid;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) begin
        o_key_valid <= s2_valid;
        if (s2_valid) begin
          o_key_data <= key_next;
          o_rule_hit <= s2_hit;
          o_rule_id  <= s2_id;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_ready & i_hdr_valid) begin
      s1_hdr    <= i_hdr_data;
      s1_fields <= type_fields;
    end
    if (s2_ready & s1_valid) begin
      s2_hdr  <= s1_hdr;
      s2_hit  <= match_hit;
      s2_id   <= match_id;
      s2_koff <= match_koff;
    end
  end

endmodule

// File: tb/tb_parser_rule_lookup.sv
// Bench for parser_rule_lookup: directed cases plus a randomized stream with backpressure,
// checked against a byte-level reference of the rule table and lookup.
module tb_parser_rule_lookup;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [23:0]  i_type_offset;
  logic [7:0]   i_typeRule_wren;
  logic         i_typeRule_valid;
  logic [63:0]  i_typeRule_typeData;
  logic [63:0]  i_typeRule_typeMask;
  logic [47:0]  i_typeRule_keyOffset;
  logic         i_hdr_valid;
  logic [511:0] i_hdr_data;
  logic         o_hdr_ready;
  logic         o_key_valid;
  logic         i_key_ready;
  logic [127:0] o_key_data;
  logic         o_rule_hit;
  logic [2:0]   o_rule_id;

  parser_rule_lookup dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_type_offset        (i_type_offset),
    .i_typeRule_wren      (i_typeRule_wren),
    .i_typeRule_valid     (i_typeRule_valid),
    .i_typeRule_typeData  (i_typeRule_typeData),
    .i_typeRule_typeMask  (i_typeRule_typeMask),
    .i_typeRule_keyOffset (i_typeRule_keyOffset),
    .i_hdr_valid          (i_hdr_valid),
    .i_hdr_data           (i_hdr_data),
    .o_hdr_ready          (o_hdr_ready),
    .o_key_valid          (o_key_valid),
    .i_key_ready          (i_key_ready),
    .o_key_data           (o_key_data),
    .o_rule_hit           (o_rule_hit),
    .o_rule_id            (o_rule_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] key;
    logic         hit;
    logic [2:0]   id;
  } res_t;

  logic        m_valid [8];
  logic [63:0] m_data  [8];
  logic [63:0] m_mask  [8];
  logic [47:0] m_koff  [8];
  res_t        exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int n_res = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [511:0] h, input int b);
    logic [511:0] s;
    if (b > 63) return 8'h00;
    s = h >> (8 * (63 - b));
    return s[7:0];
  endfunction

  function automatic logic [511:0] set_byte(input logic [511:0] h, input int b, input logic [7:0] v);
    logic [511:0] r;
    r = h;
    r[511 - 8*b -: 8] = v;
    return r;
  endfunction

  function automatic logic [15:0] fld(input logic [511:0] h, input int o);
    return {byte_at(h, o), byte_at(h, o + 1)};
  endfunction

  function automatic res_t model_lookup(input logic [511:0] h, input logic [23:0] toff);
    res_t res;
    logic ok;
    res.key = '0;
    res.hit = 1'b0;
    res.id  = '0;
    for (int r = 0; r < 8; r++) begin
      if (!res.hit && m_valid[r]) begin
        ok = 1'b1;
        for (int t = 0; t < 4; t++) begin
          if (((fld(h, int'(toff[t*6 +: 6])) ^ m_data[r][t*16 +: 16]) & m_mask[r][t*16 +: 16]) != 16'h0)
            ok = 1'b0;
        end
        if (ok) begin
          res.hit = 1'b1;
          res.id  = 3'(r);
          for (int k = 0; k < 8; k++) res.key[k*16 +: 16] = fld(h, int'(m_koff[r][k*6 +: 6]));
        end
      end
    end
    return res;
  endfunction

  // Reference bookkeeping: table writes, output comparison against the expected queue, accepts.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int r = 0; r < 8; r++) begin
        if (i_typeRule_wren[r]) begin
          m_valid[r] = i_typeRule_valid;
          m_data[r]  = i_typeRule_typeData;
          m_mask[r]  = i_typeRule_typeMask;
          m_koff[r]  = i_typeRule_keyOffset;
        end
      end
      if (o_key_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_result", 128'(o_key_valid), 128'(0));
        end else begin
          check_val("key_data", o_key_data, exp_q[0].key);
          check_val("rule_hit", 128'(o_rule_hit), 128'(exp_q[0].hit));
          check_val("rule_id", 128'(o_rule_id), 128'(exp_q[0].id));
          if (i_key_ready) begin
            void'(exp_q.pop_front());
            n_res++;
          end
        end
      end
      if (i_hdr_valid && o_hdr_ready) exp_q.push_back(model_lookup(i_hdr_data, i_type_offset));
    end
  end

  task automatic wr_rule(input logic [7:0] en, input logic v, input logic [63:0] d,
                         input logic [63:0] m, input logic [47:0] ko);
    i_typeRule_wren      = en;
    i_typeRule_valid     = v;
    i_typeRule_typeData  = d;
    i_typeRule_typeMask  = m;
    i_typeRule_keyOffset = ko;
    @(posedge i_clk); #1;
    i_typeRule_wren = '0;
  endtask

  task automatic send(input logic [511:0] h);
    logic acc;
    acc = 1'b0;
    i_hdr_data  = h;
    i_hdr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      acc = o_hdr_ready;
      @(posedge i_clk); #1;
      if (acc) break;
    end
    if (!acc) check_val("accept_timeout", 128'(acc), 128'(1));
    i_hdr_valid = 1'b0;
  endtask

  task automatic get_result(output logic [127:0] key, output logic hit, output logic [2:0] id);
    logic found;
    found = 1'b0;
    key = '0; hit = 1'b0; id = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (o_key_valid) begin
        key = o_key_data; hit = o_rule_hit; id = o_rule_id; found = 1'b1;
      end
      @(posedge i_clk); #1;
      if (found) break;
    end
    if (!found) check_val("result_timeout", 128'(found), 128'(1));
  endtask

  function automatic logic [511:0] rand_hdr();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[i*32 +: 32] = $urandom();
    return h;
  endfunction

  logic [511:0] h;
  logic [127:0] rk;
  logic         rh;
  logic [2:0]   rid;
  logic [47:0]  ko;
  int           res_base;

  initial begin
    i_rst_n = 1'b0;
    i_type_offset = '0;
    i_typeRule_wren = '0;
    i_typeRule_valid = 1'b0;
    i_typeRule_typeData = '0;
    i_typeRule_typeMask = '0;
    i_typeRule_keyOffset = '0;
    i_hdr_valid = 1'b0;
    i_hdr_data = '0;
    i_key_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      m_valid[r] = 1'b0; m_data[r] = '0; m_mask[r] = '0; m_koff[r] = '0;
    end
    repeat (3) @(posedge i_clk);
    #1;
    check_val("rst_key_valid", 128'(o_key_valid), 128'(0));
    check_val("rst_key_data", o_key_data, 128'(0));
    check_val("rst_rule_hit", 128'(o_rule_hit), 128'(0));
    check_val("rst_rule_id", 128'(o_rule_id), 128'(0));
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_val("rst_hdr_ready", 128'(o_hdr_ready), 128'(1));

    // IPv4 match with latency check
    i_type_offset = 24'd12;
    wr_rule(8'h01, 1'b1, 64'h0800, 64'hFFFF,
            {6'd0, 6'd0, 6'd0, 6'd0, 6'd32, 6'd30, 6'd28, 6'd26});
    h = rand_hdr();
    h = set_byte(h, 12, 8'h08); h = set_byte(h, 13, 8'h00);
    h = set_byte(h, 26, 8'hC0); h = set_byte(h, 27, 8'hA8);
    h = set_byte(h, 28, 8'h00); h = set_byte(h, 29, 8'h01);
    h = set_byte(h, 30, 8'h0A); h = set_byte(h, 31, 8'h00);
    h = set_byte(h, 32, 8'h00); h = set_byte(h, 33, 8'h02);
    send(h);
    @(negedge i_clk); check_val("lat_c1", 128'(o_key_valid), 128'(0));
    @(posedge i_clk); #1;
    @(negedge i_clk); check_val("lat_c2", 128'(o_key_valid), 128'(0));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_val("lat_c3", 128'(o_key_valid), 128'(1));
    check_val("ipv4_hit", 128'(o_rule_hit), 128'(1));
    check_val("ipv4_id", 128'(o_rule_id), 128'(0));
    check_val("ipv4_key", 128'(o_key_data[63:0]), 128'(64'h0002_0A00_0001_C0A8));
    @(posedge i_clk); #1;

    // priority and mask
    wr_rule(8'h04, 1'b1, 64'h0, 64'h0, 48'($urandom()));
    wr_rule(8'h20, 1'b1, 64'h86DD, 64'hFFFF, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd15, 6'd14});
    h = rand_hdr();
    h = set_byte(h, 12, 8'h86); h = set_byte(h, 13, 8'hDD);
    send(h);
    get_result(rk, rh, rid);
    check_val("prio_id_2", 128'(rid), 128'(2));
    wr_rule(8'h04, 1'b0, 64'h0, 64'h0, 48'h0);
    send(h);
    get_result(rk, rh, rid);
    check_val("prio_id_5", 128'(rid), 128'(5));
    check_val("prio_hit_5", 128'(rh), 128'(1));
    h = set_byte(h, 12, 8'h12); h = set_byte(h, 13, 8'h34);
    send(h);
    get_result(rk, rh, rid);
    check_val("miss_hit", 128'(rh), 128'(0));
    check_val("miss_key", rk, 128'(0));
    check_val("miss_id", 128'(rid), 128'(0));

    // boundary offsets
    i_type_offset = 24'd63;
    wr_rule(8'h08, 1'b1, 64'hAB00, 64'hFFFF, 48'd63);
    h = rand_hdr();
    h = set_byte(h, 62, 8'hAB); h = set_byte(h, 63, 8'hAB);
    send(h);
    get_result(rk, rh, rid);
    check_val("bound_id", 128'(rid), 128'(3));
    check_val("bound_key0", 128'(rk[15:0]), 128'(16'hAB00));
    i_type_offset = 24'd62;
    h = set_byte(h, 63, 8'h00);
    send(h);
    get_result(rk, rh, rid);
    check_val("bound62_hit", 128'(rh), 128'(1));
    check_val("bound62_key0", 128'(rk[15:0]), 128'(16'h0000));

    // randomized stream with a 5-cycle stall
    wr_rule(8'hFF, 1'b0, 64'h0, 64'h0, 48'h0);
    for (int r = 0; r < 8; r++) begin
      logic [63:0] mk;
      mk = {$urandom(), $urandom()};
      for (int t = 0; t < 4; t++) if ($urandom_range(0, 2) == 0) mk[t*16 +: 16] = 16'h0;
      wr_rule(8'(1 << r), ($urandom_range(0, 3) != 0), {$urandom(), $urandom()}, mk,
              {16'($urandom()), $urandom()});
    end
    res_base = n_res;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          logic [23:0] toff;
          int          pr;
          toff = 24'($urandom());
          h = rand_hdr();
          if (n % 2 == 0) begin
            pr = $urandom_range(0, 7);
            for (int t = 0; t < 4; t++) begin
              int o;
              o = int'(toff[t*6 +: 6]);
              h = set_byte(h, o, m_data[pr][t*16 + 8 +: 8]);
              if (o < 63) h = set_byte(h, o + 1, m_data[pr][t*16 +: 8]);
            end
          end
          i_type_offset = toff;
          send(h);
        end
      end
      begin
        repeat (8) @(posedge i_clk);
        #1;
        i_key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clk);
          check_val("stall_valid", 128'(o_key_valid), 128'(1));
          @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        check_val("stall_hdr_ready", 128'(o_hdr_ready), 128'(0));
        @(posedge i_clk); #1;
        i_key_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
          i_key_ready = 1'($urandom_range(0, 1));
          @(posedge i_clk); #1;
        end
        i_key_ready = 1'b1;
      end
    join
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge i_clk); #1;
    end
    check_val("stream_drain", 128'(exp_q.size()), 128'(0));
    check_val("stream_count", 128'(n_res - res_base), 128'(30));

    // same-cycle write versus lookup
    wr_rule(8'hFF, 1'b0, 64'h0, 64'h0, 48'h0);
    i_type_offset = 24'd12;
    wr_rule(8'h01, 1'b1, 64'h0800, 64'hFFFF, 48'h0);
    h = rand_hdr();
    h = set_byte(h, 12, 8'h08); h = set_byte(h, 13, 8'h00);
    send(h);
    wr_rule(8'h01, 1'b1, 64'h0806, 64'hFFFF, 48'h0);
    get_result(rk, rh, rid);
    check_val("collide_old_hit", 128'(rh), 128'(1));
    send(h);
    get_result(rk, rh, rid);
    check_val("collide_new_miss", 128'(rh), 128'(0));

    // reset with three headers in flight
    h = set_byte(h, 13, 8'h06);
    send(h);
    send(h);
    send(h);
    i_rst_n = 1'b0;
    #1;
    check_val("midrst_key_valid", 128'(o_key_valid), 128'(0));
    check_val("midrst_rule_hit", 128'(o_rule_hit), 128'(0));
    exp_q.delete();
    for (int r = 0; r < 8; r++) m_valid[r] = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_val("postrst_hdr_ready", 128'(o_hdr_ready), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check_val("postrst_no_stale", 128'(o_key_valid), 128'(0));
    end
    @(posedge i_clk); #1;
    send(h);
    get_result(rk, rh, rid);
    check_val("postrst_miss", 128'(rh), 128'(0));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge i_clk); #1;
    end
    check_val("final_drain", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
